memory_access: RTL and testbench

//  Y86-64 memory stage; sits directly downstream of execute. Consumes icode/valE/valA/valP,

---
 rtl/memory_access.sv | 219 +++++++++++++++++++++
 tb/tb_memory_access.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: Y86-64 memory stage.
// Performs at most one 64-bit data access per instruction over a req/ack bus.
module memory_access #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  input  logic [3:0]  icode_i,
  input  logic [2:0]  stat_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] valM_o,
  output logic [2:0]  stat_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     valm_q, valm_d;
  logic [2:0]      stat_q, stat_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            acc;
  logic            acc_we;
  logic [63:0]     acc_addr;
  logic [63:0]     acc_data;
  logic [2:0]      noacc_stat;

  // Decode icode into access kind, address source and store data source.
  always_comb begin
    acc      = 1'b0;
    acc_we   = 1'b0;
    acc_addr = valE_i;
    acc_data = valA_i;
    unique case (1'b1)
      (icode_i == I_RMMOVQ): begin
        acc    = 1'b1;
        acc_we = 1'b1;
      end
      (icode_i == I_MRMOVQ): begin
        acc = 1'b1;
      end
      (icode_i == I_CALL): begin
        acc      = 1'b1;
        acc_we   = 1'b1;
        acc_data = valP_i;
      end
      (icode_i == I_RET): begin
        acc      = 1'b1;
        acc_addr = valA_i;
      end
      (icode_i == I_PUSHQ): begin
        acc    = 1'b1;
        acc_we = 1'b1;
      end
      (icode_i == I_POPQ): begin
        acc      = 1'b1;
        acc_addr = valA_i;
      end
      default: begin
        acc = 1'b0;
      end
    endcase
  end

  // Status for instructions that finish without a bus access.
  always_comb begin
    noacc_stat = stat_i;
    if (stat_i == S_AOK && icode_i == I_HALT) begin
      noacc_stat = S_HLT;
    end
  end

  // Next-state and next-output computation for the IDLE/REQ/DONE machine.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          if (stat_i != S_AOK || !acc) begin
            state_d = DONE;
            done_d  = 1'b1;
            valm_d  = '0;
            stat_d  = noacc_stat;
          end else if (acc_addr > ADDR_MAX) begin
            state_d = DONE;
            done_d  = 1'b1;
            valm_d  = '0;
            stat_d  = S_ADR;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = acc_we;
            addr_d  = acc_addr;
            wdata_d = acc_data;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          req_d   = 1'b0;
          if (mem_err_i) begin
            stat_d = S_ADR;
            valm_d = '0;
          end else begin
            stat_d = S_AOK;
            valm_d = we_q ? 64'd0 : mem_rdata_i;
          end
        end else if (cnt_d == CNT_LIM) begin
          state_d = DONE;
          done_d  = 1'b1;
          req_d   = 1'b0;
          stat_d  = S_ADR;
          valm_d  = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      stat_q  <= S_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign valM_o      = valm_q;
  assign stat_o      = stat_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: random + directed bench for memory_access.
// Expected results come from a per-instruction timing/result model.
module tb_memory_access;

  localparam int TO = 64;
  localparam logic [63:0] AMAX = 64'd8184;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = '0;
  logic [2:0]  stat_in = 3'd1;
  logic [63:0] valE = '0;
  logic [63:0] valA = '0;
  logic [63:0] valP = '0;
  logic        busy_o, done_o;
  logic [63:0] valM_o;
  logic [2:0]  stat_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  memory_access #(.MEM_BYTES(8192), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .icode_i     (icode),
    .stat_i      (stat_in),
    .valE_i      (valE),
    .valA_i      (valA),
    .valP_i      (valP),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .valM_o      (valM_o),
    .stat_o      (stat_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .mem_err_i   (mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // model of the instruction currently in flight
  int          t_start = -1;
  int          t_done = -1;
  int          t_req_end = -1;
  bit          t_req = 1'b0;
  bit          t_we = 1'b0;
  logic [63:0] t_addr = '0;
  logic [63:0] t_wdata = '0;
  logic [63:0] t_valm = '0;
  logic [2:0]  t_stat = 3'd1;
  bit          chk_en = 1'b0;

  logic [63:0] held_valm = '0;
  logic [2:0]  held_stat = 3'd1;
  int          last_done = -1;
  int          req_cnt = 0;

  logic [63:0] mem [bit [63:0]];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0], 32'hA5A5_0F0F};
  endfunction

  // per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    bit eb;
    bit er;
    if (!rst_n) begin
      held_valm = '0;
      held_stat = 3'd1;
    end
    if (mem_req_o) req_cnt++;
    if (done_o) last_done = cyc;
    if (chk_en) begin
      eb = (cyc >= t_start) && (cyc <= t_done);
      er = t_req && (cyc >= t_start) && (cyc <= t_req_end);
      chk("busy", 64'(busy_o), 64'(eb));
      chk("done", 64'(done_o), 64'(cyc == t_done));
      chk("req", 64'(mem_req_o), 64'(er));
      if (er) begin
        chk("we", 64'(mem_we_o), 64'(t_we));
        chk("addr", mem_addr_o, t_addr);
        if (t_we) chk("wdata", mem_wdata_o, t_wdata);
      end
      if (cyc == t_done) begin
        held_valm = t_valm;
        held_stat = t_stat;
      end
      chk("valM", valM_o, held_valm);
      chk("stat", 64'(stat_o), 64'(held_stat));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      step();
      in_valid = 1'b0;
      mem_ack = 1'($urandom);
      mem_err = 1'($urandom);
    end
  endtask

  // Issue one instruction at the current cycle and run it to completion.
  task automatic issue(input logic [3:0] ic, input logic [2:0] st,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [63:0] vp, input int dly,
                       input bit err, output int n_o);
    bit          acc;
    bit          we;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] rdv;
    int          n;
    int          ack_c;
    bit          in_req;
    acc = (st == 3'd1) && (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 ||
                           ic == 4'h9 || ic == 4'hA || ic == 4'hB);
    we  = (ic == 4'h4 || ic == 4'h8 || ic == 4'hA);
    a   = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    d   = (ic == 4'h8) ? vp : va;
    n   = cyc;
    n_o = n;
    ack_c = -1;
    rdv = rd(a);
    in_valid = 1'b1;
    icode = ic;
    stat_in = st;
    valE = ve;
    valA = va;
    valP = vp;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    t_start = n + 1;
    t_req = 1'b0;
    t_we = we;
    t_addr = a;
    t_wdata = d;
    t_valm = '0;
    if (!acc) begin
      t_done = n + 1;
      if (st != 3'd1) t_stat = st;
      else t_stat = (ic == 4'h0) ? 3'd2 : 3'd1;
    end else if (a > AMAX) begin
      t_done = n + 1;
      t_stat = 3'd3;
    end else begin
      t_req = 1'b1;
      if (dly >= TO) begin
        t_req_end = n + TO;
        t_done = n + TO + 1;
        t_stat = 3'd3;
      end else begin
        ack_c = n + 1 + dly;
        t_req_end = ack_c;
        t_done = ack_c + 1;
        if (err) begin
          t_stat = 3'd3;
        end else begin
          t_stat = 3'd1;
          if (we) mem[a] = d;
          else t_valm = rdv;
        end
      end
    end
    while (cyc < t_done) begin
      step();
      in_valid = ($urandom_range(0, 3) == 0);
      icode = 4'($urandom);
      stat_in = 3'($urandom);
      valE = {$urandom, $urandom};
      valA = {$urandom, $urandom};
      in_req = t_req && (cyc <= t_req_end);
      if (cyc == ack_c) begin
        mem_ack = 1'b1;
        mem_err = err;
        mem_rdata = rdv;
      end else begin
        mem_ack = in_req ? 1'b0 : 1'($urandom);
        mem_err = 1'($urandom);
        mem_rdata = {$urandom, $urandom};
      end
    end
    step();
    in_valid = 1'b0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 64'h0;
      1: return 64'h8;
      2: return 64'h100;
      3: return 64'h1FF8;
      4: return 64'h1FF9;
      5: return 64'h2000;
      6: return 64'hFFFF_FFFF_FFFF_FFF8;
      7: return 64'h1FF0;
      default: return 64'($urandom_range(0, 8184));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int d0;
    int r;
    int dly;
    bit err;
    logic [3:0] ics [8];
    ics = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h6};

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_valM", valM_o, 64'd0);
    chk("rst_stat", 64'(stat_o), 64'd1);
    chk("rst_addr", mem_addr_o, 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    mem[64'h100] = 64'hDEAD_BEEF;
    r0 = req_cnt;
    issue(4'h5, 3'd1, 64'h100, 64'h0, 64'h0, 3, 1'b0, n);
    chk("mr_valM", valM_o, 64'hDEAD_BEEF);
    chk("mr_stat", 64'(stat_o), 64'd1);
    chk("mr_lat", 64'(last_done - n), 64'd5);
    chk("mr_reqcyc", 64'(req_cnt - r0), 64'd4);

    r0 = req_cnt;
    issue(4'hA, 3'd1, 64'h1FF8, 64'h55, 64'h0, 0, 1'b0, n);
    chk("push_lat", 64'(last_done - n), 64'd2);
    chk("push_stat", 64'(stat_o), 64'd1);
    chk("push_reqcyc", 64'(req_cnt - r0), 64'd1);

    r0 = req_cnt;
    issue(4'h4, 3'd1, 64'h1FF9, 64'h7, 64'h0, 0, 1'b0, n);
    chk("rm_oob_lat", 64'(last_done - n), 64'd1);
    chk("rm_oob_stat", 64'(stat_o), 64'd3);
    chk("rm_oob_noreq", 64'(req_cnt - r0), 64'd0);

    r0 = req_cnt;
    issue(4'h9, 3'd1, 64'h0, 64'h40, 64'h0, TO, 1'b0, n);
    chk("to_lat", 64'(last_done - n), 64'd65);
    chk("to_stat", 64'(stat_o), 64'd3);
    chk("to_reqcyc", 64'(req_cnt - r0), 64'd64);
    d0 = last_done;
    repeat (3) begin
      step();
      mem_ack = 1'b1;
    end
    step();
    mem_ack = 1'b0;
    chk("to_late_ack", 64'(last_done), 64'(d0));

    issue(4'h6, 3'd1, 64'h0, 64'h0, 64'h0, 0, 1'b0, n);
    chk("opq_lat", 64'(last_done - n), 64'd1);
    chk("opq_stat", 64'(stat_o), 64'd1);
    issue(4'h0, 3'd1, 64'h0, 64'h0, 64'h0, 0, 1'b0, n);
    chk("halt_lat", 64'(last_done - n), 64'd1);
    chk("halt_stat", 64'(stat_o), 64'd2);

    chk_en = 1'b0;
    in_valid = 1'b1;
    icode = 4'h5;
    stat_in = 3'd1;
    valE = 64'h200;
    step();
    in_valid = 1'b0;
    mem_ack = 1'b0;
    step();
    chk("rst_mid_pre_req", 64'(mem_req_o), 64'd1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_req", 64'(mem_req_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_stat", 64'(stat_o), 64'd1);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    rst_n = 1'b1;
    d0 = last_done;
    t_start = -1;
    t_done = -1;
    t_req = 1'b0;
    chk_en = 1'b1;
    repeat (4) begin
      step();
      mem_ack = 1'($urandom);
    end
    mem_ack = 1'b0;
    chk("rst_mid_nodone", 64'(last_done), 64'(d0));

    for (int k = 0; k < 200; k++) begin
      logic [3:0] ic;
      logic [2:0] st;
      if ($urandom_range(0, 3) == 0) ic = 4'($urandom);
      else ic = ics[$urandom_range(0, 7)];
      st = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      r = $urandom_range(0, 49);
      err = 1'b0;
      if (r == 0) begin
        dly = TO;
      end else if (r < 6) begin
        dly = $urandom_range(0, 4);
        err = 1'b1;
      end else begin
        dly = $urandom_range(0, 4);
      end
      issue(ic, st, pick_addr(), pick_addr(), {$urandom, $urandom},
            dly, err, n);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
